// File: rtl/controller_status_pkg.sv
// Shared definitions for the system-status collector: word width, bit roles
// and the default set of sticky (latched) status bits.
package controller_status_pkg;

    localparam int STATUS_W = 3;

    localparam int STAT_LINK_UP    = 0;
    localparam int STAT_DATA_VALID = 1;
    localparam int STAT_FAULT      = 2;

    localparam logic [STATUS_W-1:0] STATUS_STICKY_DEFAULT = 3'b100;

    // A one-cycle debounce still needs a 1-bit counter so the compare is well formed.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/controller_status_collector_if.sv
// Status bus between the raw sources / software clear and the collector,
// whose conditioned word feeds the system-status PIO.
interface controller_status_collector_if;
    import controller_status_pkg::*;

    logic [STATUS_W-1:0] status_raw;
    logic                clear_sticky;
    logic [STATUS_W-1:0] status_out;
    logic                status_changed;

    modport master (
        output status_raw,
        output clear_sticky,
        input  status_out,
        input  status_changed
    );

    modport slave (
        input  status_raw,
        input  clear_sticky,
        output status_out,
        output status_changed
    );

endinterface

// File: rtl/controller_status_debounce.sv
// One status bit: two-flop synchronizer followed by a hold-time debouncer.
// rise flags the edge at which the accepted level goes 0->1.
module controller_status_debounce
    import controller_status_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != stable) && (cnt == CNT_LAST);
    assign rise   = accept & sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts the hold count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controller_status_collector.sv
// Conditions the raw status sources into the PIO status word: per-bit
// debounce, sticky fault latching with software clear, and a change strobe.
module controller_status_collector
    import controller_status_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [STATUS_W-1:0] STICKY_MASK     = STATUS_STICKY_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    controller_status_collector_if.slave  bus
);

    logic [STATUS_W-1:0] stable;
    logic [STATUS_W-1:0] rise;
    logic [STATUS_W-1:0] sticky;
    logic [STATUS_W-1:0] clear_req;
    logic [STATUS_W-1:0] status_out;
    logic [STATUS_W-1:0] status_out_d;
    logic                status_changed;

    for (genvar i = 0; i < STATUS_W; i++) begin : g_bit
        controller_status_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.status_raw[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // A clear only lands on bits whose source has already debounced low;
    // a simultaneous rise overrides it.
    assign clear_req = {STATUS_W{bus.clear_sticky}} & ~stable & ~rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= ((sticky | rise) & ~clear_req) & STICKY_MASK;
        end
    end

    assign status_out = (sticky & STICKY_MASK) | (stable & ~STICKY_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_out_d   <= '0;
            status_changed <= 1'b0;
        end else begin
            status_out_d   <= status_out;
            status_changed <= (status_out != status_out_d);
        end
    end

    assign bus.status_out     = status_out;
    assign bus.status_changed = status_changed;

endmodule

// File: tb/tb_controller_status_collector.sv
// Directed bench for the status collector: a default instance and a
// DEBOUNCE_CYCLES=1 / no-sticky instance, both checked every cycle against a model.
module tb_controller_status_collector;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] raw_in [2];
    logic       clr_in [2];

    int n_cmp = 0;
    int n_bad = 0;

    controller_status_collector_if bus0 ();
    controller_status_collector_if bus1 ();

    assign bus0.status_raw   = raw_in[0];
    assign bus0.clear_sticky = clr_in[0];
    assign bus1.status_raw   = raw_in[1];
    assign bus1.clear_sticky = clr_in[1];

    controller_status_collector u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    controller_status_collector #(
        .DEBOUNCE_CYCLES (1),
        .STICKY_MASK     (3'b000)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bit's accepted level flips once the synchronized
    // sample has disagreed with it for D consecutive edges.
    int         m_deb [2] = '{16, 1};
    logic [2:0] m_mask[2] = '{3'b100, 3'b000};
    logic [2:0] m_s1[2], m_s2[2], m_stab[2], m_stk[2], m_od[2];
    logic       m_chg[2];
    int         run[2][3];

    function automatic logic [2:0] m_out(input int k);
        return (m_stk[k] & m_mask[k]) | (m_stab[k] & ~m_mask[k]);
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] o, nstab, rs;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_s1[k] = 0; m_s2[k] = 0; m_stab[k] = 0; m_stk[k] = 0;
                m_od[k] = 0; m_chg[k] = 0;
                for (int i = 0; i < 3; i++) run[k][i] = 0;
            end else begin
                o     = m_out(k);
                nstab = m_stab[k];
                rs    = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    if (m_s2[k][i] == m_stab[k][i]) run[k][i] = 0;
                    else begin
                        run[k][i]++;
                        if (run[k][i] == m_deb[k]) begin
                            nstab[i] = m_s2[k][i];
                            rs[i]    = m_s2[k][i];
                            run[k][i] = 0;
                        end
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (rs[i]) m_stk[k][i] = 1'b1;
                    else if (clr_in[k] && !m_stab[k][i]) m_stk[k][i] = 1'b0;
                end
                m_chg[k]  = (o != m_od[k]);
                m_od[k]   = o;
                m_stab[k] = nstab;
                m_s2[k]   = m_s1[k];
                m_s1[k]   = raw_in[k];
            end
        end
        #1;
        check("out0_model", bus0.status_out, m_out(0));
        check("chg0_model", {2'b00, bus0.status_changed}, {2'b00, m_chg[0]});
        check("out1_model", bus1.status_out, m_out(1));
        check("chg1_model", {2'b00, bus1.status_changed}, {2'b00, m_chg[1]});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        raw_in[0] = 3'b000; raw_in[1] = 3'b000;
        clr_in[0] = 1'b0;   clr_in[1] = 1'b0;
        tick(2);
        check("reset_out", bus0.status_out, 3'b000);
        reset = 1'b0;
        tick(2);

        // Reset in the middle of a debounce, then a full re-debounce.
        raw_in[0] = 3'b111;
        tick(8);
        reset = 1'b1;
        #1;
        check("reset_async_out", bus0.status_out, 3'b000);
        check("reset_async_chg", {2'b00, bus0.status_changed}, 3'b000);
        tick(2);
        reset = 1'b0;
        tick(17);
        check("redeb_edge16", bus0.status_out, 3'b000);
        tick();
        check("redeb_edge17", bus0.status_out, 3'b111);
        check("redeb_nochg17", {2'b00, bus0.status_changed}, 3'b000);
        tick();
        check("redeb_chg18", {2'b00, bus0.status_changed}, 3'b001);
        tick();
        check("redeb_chg19", {2'b00, bus0.status_changed}, 3'b000);

        raw_in[0] = 3'b000;
        tick(20);
        check("sticky_after_fall", bus0.status_out, 3'b100);
        clr_in[0] = 1'b1;
        tick();
        clr_in[0] = 1'b0;
        check("sticky_cleared", bus0.status_out, 3'b000);
        tick(3);

        // 15-cycle glitch rejected, 16-cycle level accepted.
        raw_in[0] = 3'b001;
        tick(15);
        raw_in[0] = 3'b000;
        for (int t = 0; t < 25; t++) begin
            tick();
            check("glitch_out", bus0.status_out, 3'b000);
            check("glitch_chg", {2'b00, bus0.status_changed}, 3'b000);
        end
        raw_in[0] = 3'b001;
        tick(17);
        check("accept_edge16", bus0.status_out, 3'b000);
        tick();
        check("accept_edge17", bus0.status_out, 3'b001);
        raw_in[0] = 3'b000;
        tick(20);

        // Sticky hold and clear after the source debounces low.
        raw_in[0] = 3'b100;
        tick(20);
        raw_in[0] = 3'b000;
        tick(40);
        check("sticky_hold", bus0.status_out, 3'b100);
        clr_in[0] = 1'b1;
        tick();
        clr_in[0] = 1'b0;
        check("sticky_clear_pulse", bus0.status_out, 3'b000);
        tick(3);

        // Clear held across the set edge, while active, and through the fall.
        clr_in[0] = 1'b1;
        raw_in[0] = 3'b100;
        tick(17);
        check("collide_edge16", bus0.status_out, 3'b000);
        tick();
        check("collide_set_wins", bus0.status_out, 3'b100);
        tick(25);
        check("clear_while_active", bus0.status_out, 3'b100);
        raw_in[0] = 3'b000;
        tick(18);
        check("clear_src_just_low", bus0.status_out, 3'b100);
        tick();
        check("clear_after_low", bus0.status_out, 3'b000);
        clr_in[0] = 1'b0;
        tick(3);

        // DEBOUNCE_CYCLES=1, nothing sticky.
        raw_in[1] = 3'b101;
        tick(2);
        check("d1_rise_edge1", bus1.status_out, 3'b000);
        tick();
        check("d1_rise_edge2", bus1.status_out, 3'b101);
        tick();
        check("d1_chg_edge3", {2'b00, bus1.status_changed}, 3'b001);
        raw_in[1] = 3'b000;
        tick(2);
        check("d1_fall_edge1", bus1.status_out, 3'b101);
        tick();
        check("d1_fall_edge2", bus1.status_out, 3'b000);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
